// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg
// Shared types and constants for the DDR request arbiter.
//   - arb_state_e : transaction FSM states (IDLE, ISSUE, WAIT, RESP)
//   - port_id_e   : requester identity (PORT_IF fetch, PORT_LSU load/store)
//   - DEF_ADDR_W  : default DDR entry-index width in 64-bit words
//   - WORD_W / LINE_W / BURST_LEN : LSU word, fetch line and burst geometry
//   - WD_CNT_W    : width of the optional WAIT watchdog counter
package ddr_arb_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int WORD_W     = 64;
    localparam int LINE_W     = 512;
    localparam int BURST_LEN  = LINE_W / WORD_W;
    localparam int WD_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_LSU = 1'b1
    } port_id_e;

    // The port that did not win last time.
    function automatic port_id_e other_port(input port_id_e p);
        port_id_e r;
        case (p)
            PORT_IF:  r = PORT_LSU;
            PORT_LSU: r = PORT_IF;
            default:  r = PORT_LSU;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ddr_rr_arb2.sv
// ddr_rr_arb2
// Two-way round-robin grant between the fetch and LSU requesters.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   req_if, req_lsu    : qualified requests (already gated by the caller)
//   advance            : a grant is being taken this cycle; update the pointer
//   grant_if, grant_lsu: combinational one-hot grant (both 0 when idle)
// After reset the pointer favours the LSU.
module ddr_rr_arb2
    import ddr_arb_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_if,
    input  logic req_lsu,
    input  logic advance,
    output logic grant_if,
    output logic grant_lsu
);

    port_id_e last_r;
    port_id_e pick_s;

    // Choose the winner: on contention, the port not granted last.
    always_comb begin
        pick_s    = PORT_LSU;
        grant_if  = 1'b0;
        grant_lsu = 1'b0;
        if (req_if && req_lsu) begin
            pick_s = other_port(last_r);
        end else if (req_if) begin
            pick_s = PORT_IF;
        end else begin
            pick_s = PORT_LSU;
        end
        if (req_if || req_lsu) begin
            grant_if  = (pick_s == PORT_IF);
            grant_lsu = (pick_s == PORT_LSU);
        end else begin
            grant_if  = 1'b0;
            grant_lsu = 1'b0;
        end
    end

    // Remember the last winner; resetting to IF makes LSU win first.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_r <= PORT_IF;
        end else if (advance && (req_if || req_lsu)) begin
            last_r <= pick_s;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/ddr_req_arbiter.sv
// ddr_req_arbiter
// Arbitrates the instruction-fetch port and the LSU port onto a single DDR
// request channel, one transaction at a time (IDLE -> ISSUE -> WAIT -> RESP).
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   if_req_* / if_flush   : fetch request (512-bit line, 8-word aligned burst)
//   if_resp_valid/_data   : fetch response, one-cycle pulse
//   lsu_req_*             : LSU single-word read/write request
//   lsu_resp_valid/_rdata : LSU response pulse (rdata 0 for writes)
//   ddr_*                 : DDR request fields (held from ISSUE to WAIT exit)
//                           and DDR completion/data inputs
//   timeout_err           : sticky watchdog error
// Build option: define DDR_ARB_WATCHDOG_EN to enable the WAIT watchdog that
// forces a zero-data response after TIMEOUT_CYC WAIT cycles.
module ddr_req_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int TIMEOUT_CYC = 200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_index,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [LINE_W-1:0] if_resp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_index,
    input  logic              lsu_req_write,
    input  logic [WORD_W-1:0] lsu_req_wdata,
    input  logic [WORD_W-1:0] lsu_req_wmask,
    output logic              lsu_resp_valid,
    output logic [WORD_W-1:0] lsu_resp_rdata,
    output logic              ddr_chip_enable,
    output logic [ADDR_W-1:0] ddr_index,
    output logic              ddr_write_enable,
    output logic              ddr_burst_mode,
    output logic [WORD_W-1:0] ddr_opstore_write_data,
    output logic [WORD_W-1:0] ddr_opstore_write_mask,
    output logic [LINE_W-1:0] ddr_l2_write_data,
    input  logic              ddr_ready,
    input  logic              ddr_operation_done,
    input  logic [WORD_W-1:0] ddr_opload_read_data,
    input  logic [LINE_W-1:0] ddr_pc_read_inst,
    output logic              timeout_err
);

    // Clears the word-within-line bits so fetches start on a line boundary.
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN - 1);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << WD_CNT_W)) begin : g_timeout_range
        $error("TIMEOUT_CYC does not fit the watchdog counter");
    end

    arb_state_e state_r;
    port_id_e   owner_r;
    logic       drop_r;
    logic       req_if_s;
    logic       req_lsu_s;
    logic       start_s;
    logic       grant_if_s;
    logic       grant_lsu_s;
    logic       timeout_hit_s;
    logic       wait_exit_s;

    assign ddr_l2_write_data = {LINE_W{1'b0}};

    // A flush in IDLE masks the fetch request for that cycle.
    assign req_if_s  = if_req_valid && !if_flush;
    assign req_lsu_s = lsu_req_valid;
    assign start_s   = (state_r == ST_IDLE) && ddr_ready && (req_if_s || req_lsu_s);
    assign wait_exit_s = ddr_operation_done || timeout_hit_s;

    ddr_rr_arb2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .req_if    (req_if_s),
        .req_lsu   (req_lsu_s),
        .advance   (start_s),
        .grant_if  (grant_if_s),
        .grant_lsu (grant_lsu_s)
    );

`ifdef DDR_ARB_WATCHDOG_EN
    localparam logic [WD_CNT_W-1:0] WD_LAST = WD_CNT_W'(TIMEOUT_CYC - 1);

    logic [WD_CNT_W-1:0] wd_cnt_r;
    logic                timeout_err_r;

    // Done wins over the watchdog when both land in the same cycle.
    assign timeout_hit_s = (state_r == ST_WAIT) && !ddr_operation_done && (wd_cnt_r == WD_LAST);
    assign timeout_err   = timeout_err_r;

    // WAIT-cycle counter (cleared whenever WAIT is left) and sticky error.
    always_ff @(posedge clock) begin
        if (reset) begin
            wd_cnt_r      <= {WD_CNT_W{1'b0}};
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_r == ST_WAIT) && !wait_exit_s) begin
                wd_cnt_r <= wd_cnt_r + WD_CNT_W'(1'b1);
            end else begin
                wd_cnt_r <= {WD_CNT_W{1'b0}};
            end
            if (timeout_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end
`else
    assign timeout_hit_s = 1'b0;
    assign timeout_err   = 1'b0;
`endif

    // Transaction FSM with all handshake, DDR and response outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r                <= ST_IDLE;
            owner_r                <= PORT_LSU;
            drop_r                 <= 1'b0;
            if_req_ready           <= 1'b0;
            lsu_req_ready          <= 1'b0;
            if_resp_valid          <= 1'b0;
            lsu_resp_valid         <= 1'b0;
            if_resp_data           <= {LINE_W{1'b0}};
            lsu_resp_rdata         <= {WORD_W{1'b0}};
            ddr_chip_enable        <= 1'b0;
            ddr_index              <= {ADDR_W{1'b0}};
            ddr_write_enable       <= 1'b0;
            ddr_burst_mode         <= 1'b0;
            ddr_opstore_write_data <= {WORD_W{1'b0}};
            ddr_opstore_write_mask <= {WORD_W{1'b0}};
        end else begin
            // Single-cycle strobes default low.
            if_req_ready    <= 1'b0;
            lsu_req_ready   <= 1'b0;
            if_resp_valid   <= 1'b0;
            lsu_resp_valid  <= 1'b0;
            ddr_chip_enable <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r         <= ST_ISSUE;
                        drop_r          <= 1'b0;
                        ddr_chip_enable <= 1'b1;
                        if (grant_lsu_s) begin
                            owner_r                <= PORT_LSU;
                            lsu_req_ready          <= 1'b1;
                            ddr_index              <= lsu_req_index;
                            ddr_write_enable       <= lsu_req_write;
                            ddr_burst_mode         <= 1'b0;
                            ddr_opstore_write_data <= lsu_req_wdata;
                            ddr_opstore_write_mask <= lsu_req_wmask;
                        end else begin
                            owner_r                <= PORT_IF;
                            if_req_ready           <= 1'b1;
                            ddr_index              <= if_req_index & LINE_MASK;
                            ddr_write_enable       <= 1'b0;
                            ddr_burst_mode         <= 1'b1;
                            ddr_opstore_write_data <= {WORD_W{1'b0}};
                            ddr_opstore_write_mask <= {WORD_W{1'b0}};
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                    if ((owner_r == PORT_IF) && if_flush) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                end
                ST_WAIT: begin
                    if ((owner_r == PORT_IF) && if_flush) begin
                        drop_r <= 1'b1;
                    end else begin
                        drop_r <= drop_r;
                    end
                    if (wait_exit_s) begin
                        state_r <= ST_RESP;
                        // Response data is captured on the edge that enters RESP.
                        if (owner_r == PORT_LSU) begin
                            lsu_resp_valid <= 1'b1;
                            if (ddr_operation_done && !ddr_write_enable) begin
                                lsu_resp_rdata <= ddr_opload_read_data;
                            end else begin
                                lsu_resp_rdata <= {WORD_W{1'b0}};
                            end
                        end else begin
                            if_resp_valid <= !(drop_r || if_flush);
                            if (ddr_operation_done) begin
                                if_resp_data <= ddr_pc_read_inst;
                            end else begin
                                if_resp_data <= {LINE_W{1'b0}};
                            end
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                    drop_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    drop_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_req_arbiter.sv
module tb_ddr_req_arbiter;

    localparam int AW = 19;

    logic           clock = 1'b0;
    logic           reset;
    logic           if_req_valid, if_req_ready, if_flush, if_resp_valid;
    logic [AW-1:0]  if_req_index;
    logic [511:0]   if_resp_data;
    logic           lsu_req_valid, lsu_req_ready, lsu_req_write, lsu_resp_valid;
    logic [AW-1:0]  lsu_req_index;
    logic [63:0]    lsu_req_wdata, lsu_req_wmask, lsu_resp_rdata;
    logic           ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
    logic [AW-1:0]  ddr_index;
    logic [63:0]    ddr_opstore_write_data, ddr_opstore_write_mask;
    logic [511:0]   ddr_l2_write_data;
    logic           ddr_ready, ddr_operation_done;
    logic [63:0]    ddr_opload_read_data;
    logic [511:0]   ddr_pc_read_inst;
    logic           timeout_err;

    always #5 clock = ~clock;

    ddr_req_arbiter #(.ADDR_W(AW), .TIMEOUT_CYC(200)) dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_index(if_req_index),
        .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_index(lsu_req_index),
        .lsu_req_write(lsu_req_write), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
        .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index), .ddr_write_enable(ddr_write_enable),
        .ddr_burst_mode(ddr_burst_mode), .ddr_opstore_write_data(ddr_opstore_write_data),
        .ddr_opstore_write_mask(ddr_opstore_write_mask), .ddr_l2_write_data(ddr_l2_write_data),
        .ddr_ready(ddr_ready), .ddr_operation_done(ddr_operation_done),
        .ddr_opload_read_data(ddr_opload_read_data), .ddr_pc_read_inst(ddr_pc_read_inst),
        .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory contents: each 64-bit word is derived from its own index.
    function automatic logic [63:0] mem_word(input logic [AW-1:0] a);
        return {16'hC0DE, 13'd0, a, 16'h5A5A};
    endfunction

    function automatic logic [511:0] mem_line(input logic [AW-1:0] base);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = mem_word(base + AW'(i));
        return l;
    endfunction

    // ---------------- DDR responder model ----------------
    int            resp_lat = 4;
    bit            resp_hang = 1'b0;
    bit            busy = 1'b0;
    int            rcnt = 0;
    int            done_cnt = 0;
    int            stable_err = 0;
    logic [AW-1:0] r_idx;
    logic          r_we, r_burst;
    logic [63:0]   r_wd, r_wm;

    always @(negedge clock) begin
        ddr_operation_done   = 1'b0;
        ddr_opload_read_data = 64'hFFFF_FFFF_FFFF_FFFF;
        ddr_pc_read_inst     = {512{1'b1}};
        if (reset === 1'b1) begin
            busy = 1'b0;
        end else if (busy) begin
            if (ddr_index !== r_idx || ddr_write_enable !== r_we || ddr_burst_mode !== r_burst ||
                ddr_opstore_write_data !== r_wd || ddr_opstore_write_mask !== r_wm)
                stable_err++;
            if (rcnt == 1) begin
                busy = 1'b0;
                ddr_operation_done = 1'b1;
                done_cnt++;
                if (r_burst) ddr_pc_read_inst = mem_line(r_idx);
                else if (r_we) ddr_opload_read_data = 64'hBAD0_BAD0_BAD0_BAD0;
                else ddr_opload_read_data = mem_word(r_idx);
            end else begin
                rcnt--;
            end
        end else if (ddr_chip_enable === 1'b1 && !resp_hang) begin
            busy = 1'b1; rcnt = resp_lat;
            r_idx = ddr_index; r_we = ddr_write_enable; r_burst = ddr_burst_mode;
            r_wd = ddr_opstore_write_data; r_wm = ddr_opstore_write_mask;
        end
    end

    int if_resp_cnt = 0;
    int lsu_resp_cnt = 0;
    always @(negedge clock) begin
        if (if_resp_valid === 1'b1) if_resp_cnt++;
        if (lsu_resp_valid === 1'b1) lsu_resp_cnt++;
    end

    // ---------------- vector table ----------------
    typedef struct {
        bit            is_lsu;
        logic [AW-1:0] idx;
        bit            wr;
        logic [63:0]   wd;
        logic [63:0]   wm;
        int            lat;
        bit            fl;
        logic [AW-1:0] exp_idx;
        bit            exp_burst;
        bit            exp_we;
        logic [63:0]   exp_lsu;
    } vec_t;

    vec_t vt[6];

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 512'({if_req_ready, lsu_req_ready}), 512'(0));
        chk({tag, "_resp_valid"}, 512'({if_resp_valid, lsu_resp_valid}), 512'(0));
        chk({tag, "_ddr_ctl"}, 512'({ddr_chip_enable, ddr_write_enable, ddr_burst_mode}), 512'(0));
        chk({tag, "_ddr_index"}, 512'(ddr_index), 512'(0));
        chk({tag, "_ddr_wdata_mask"}, 512'({ddr_opstore_write_data, ddr_opstore_write_mask}), 512'(0));
        chk({tag, "_resp_data"}, if_resp_data | 512'(lsu_resp_rdata), 512'(0));
        chk({tag, "_timeout_err"}, 512'(timeout_err), 512'(0));
        chk({tag, "_l2_wdata"}, ddr_l2_write_data, 512'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_req_valid = 1'b0; lsu_req_valid = 1'b0; if_flush = 1'b0;
        repeat (2) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
    endtask

    // One complete transaction with field, latency and response checks.
    task automatic run_req(input vec_t v, input string tag);
        bit got;
        int n;
        stable_err = 0;
        resp_lat = v.lat;
        @(negedge clock);
        if_flush = v.fl;
        if (v.is_lsu) begin
            lsu_req_valid = 1'b1; lsu_req_index = v.idx; lsu_req_write = v.wr;
            lsu_req_wdata = v.wd; lsu_req_wmask = v.wm;
        end else begin
            if_req_valid = 1'b1; if_req_index = v.idx;
        end
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if ((v.is_lsu ? lsu_req_ready : if_req_ready) === 1'b1) begin got = 1'b1; break; end
        end
        chk({tag, "_grant"}, 512'(got), 512'(1));
        lsu_req_valid = 1'b0; if_req_valid = 1'b0;
        if (got) begin
            chk({tag, "_chip_enable"}, 512'(ddr_chip_enable), 512'(1));
            chk({tag, "_ddr_index"}, 512'(ddr_index), 512'(v.exp_idx));
            chk({tag, "_burst_we"}, 512'({ddr_burst_mode, ddr_write_enable}), 512'({v.exp_burst, v.exp_we}));
            if (v.is_lsu && v.wr)
                chk({tag, "_wdata_mask"}, 512'({ddr_opstore_write_data, ddr_opstore_write_mask}), 512'({v.wd, v.wm}));
            got = 1'b0; n = 0;
            for (int c = 0; c < v.lat + 30; c++) begin
                @(negedge clock);
                n++;
                if ((v.is_lsu ? lsu_resp_valid : if_resp_valid) === 1'b1) begin got = 1'b1; break; end
            end
            chk({tag, "_resp_seen"}, 512'(got), 512'(1));
            chk({tag, "_latency"}, 512'(n), 512'(v.lat + 1));
            if (v.is_lsu) chk({tag, "_lsu_rdata"}, 512'(lsu_resp_rdata), 512'(v.exp_lsu));
            else chk({tag, "_if_line"}, if_resp_data, mem_line(v.exp_idx));
            @(negedge clock);
            chk({tag, "_resp_one_cycle"}, 512'({if_resp_valid, lsu_resp_valid}), 512'(0));
            chk({tag, "_fields_stable"}, 512'(stable_err), 512'(0));
        end
        if_flush = 1'b0;
    endtask

    // Wait for a grant of the given port (bounded), then drop its valid.
    task automatic wait_grant(input bit lsu, input int budget, input string tag, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if ((lsu ? lsu_req_ready : if_req_ready) === 1'b1) begin got = 1'b1; break; end
        end
        chk({tag, "_grant"}, 512'(got), 512'(1));
        if (lsu) lsu_req_valid = 1'b0; else if_req_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        bit got;
        int ng, ce, b_if, b_lsu, b_done, n;
        logic [3:0] order;

        vt[0] = '{is_lsu:1'b0, idx:19'h1234B, wr:1'b0, wd:64'h0, wm:64'h0, lat:80, fl:1'b0,
                  exp_idx:19'h12348, exp_burst:1'b1, exp_we:1'b0, exp_lsu:64'h0};
        vt[1] = '{is_lsu:1'b1, idx:19'h00010, wr:1'b1, wd:64'hDEADBEEF, wm:64'hFFFFFFFF, lat:64, fl:1'b0,
                  exp_idx:19'h00010, exp_burst:1'b0, exp_we:1'b1, exp_lsu:64'h0};
        vt[2] = '{is_lsu:1'b1, idx:19'h7FFFF, wr:1'b0, wd:64'h0, wm:64'h0, lat:3, fl:1'b0,
                  exp_idx:19'h7FFFF, exp_burst:1'b0, exp_we:1'b0, exp_lsu:mem_word(19'h7FFFF)};
        vt[3] = '{is_lsu:1'b0, idx:19'h00007, wr:1'b0, wd:64'h0, wm:64'h0, lat:1, fl:1'b0,
                  exp_idx:19'h00000, exp_burst:1'b1, exp_we:1'b0, exp_lsu:64'h0};
        vt[4] = '{is_lsu:1'b0, idx:19'h7FFFF, wr:1'b0, wd:64'h0, wm:64'h0, lat:5, fl:1'b0,
                  exp_idx:19'h7FFF8, exp_burst:1'b1, exp_we:1'b0, exp_lsu:64'h0};
        vt[5] = '{is_lsu:1'b1, idx:19'h00033, wr:1'b0, wd:64'h0, wm:64'h0, lat:6, fl:1'b1,
                  exp_idx:19'h00033, exp_burst:1'b0, exp_we:1'b0, exp_lsu:mem_word(19'h00033)};

        ddr_ready = 1'b1;
        if_req_index = '0; lsu_req_index = '0; lsu_req_write = 1'b0;
        lsu_req_wdata = '0; lsu_req_wmask = '0;
        do_reset();

        for (int i = 0; i < 6; i++) run_req(vt[i], $sformatf("vec%0d", i));

        // Round robin: both ports valid continuously for four grants.
        do_reset();
        resp_lat = 4;
        b_if = if_resp_cnt; b_lsu = lsu_resp_cnt;
        @(negedge clock);
        if_req_valid = 1'b1; if_req_index = 19'h00100;
        lsu_req_valid = 1'b1; lsu_req_index = 19'h00020; lsu_req_write = 1'b0;
        ng = 0; order = 4'b0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            @(negedge clock);
            if (ddr_chip_enable === 1'b1) begin order[ng] = ~ddr_burst_mode; ng++; end
        end
        if_req_valid = 1'b0; lsu_req_valid = 1'b0;
        repeat (20) @(negedge clock);
        chk("rr_grant_count", 512'(ng), 512'(4));
        chk("rr_order_lsu_if_lsu_if", 512'(order), 512'(4'b0101));
        chk("rr_resp_counts", 512'({16'(if_resp_cnt - b_if), 16'(lsu_resp_cnt - b_lsu)}), 512'({16'd2, 16'd2}));

        // Flush at WAIT cycle 30: DDR completes, no fetch response.
        resp_lat = 80;
        b_if = if_resp_cnt; b_done = done_cnt;
        @(negedge clock);
        if_req_valid = 1'b1; if_req_index = 19'h02000;
        wait_grant(1'b0, 20, "flush", got);
        for (int k = 1; k <= 100; k++) begin
            @(negedge clock);
            if (k == 30) if_flush = 1'b1;
            if (k == 31) if_flush = 1'b0;
        end
        chk("flush_no_if_resp", 512'(if_resp_cnt - b_if), 512'(0));
        chk("flush_ddr_completed", 512'(done_cnt - b_done), 512'(1));
        run_req('{is_lsu:1'b0, idx:19'h00045, wr:1'b0, wd:64'h0, wm:64'h0, lat:2, fl:1'b0,
                  exp_idx:19'h00040, exp_burst:1'b1, exp_we:1'b0, exp_lsu:64'h0}, "after_flush");

        // Flush in IDLE blocks the fetch grant.
        resp_lat = 2;
        @(negedge clock);
        if_flush = 1'b1; if_req_valid = 1'b1; if_req_index = 19'h00080;
        ce = 0;
        repeat (6) begin
            @(negedge clock);
            if (ddr_chip_enable === 1'b1 || if_req_ready === 1'b1) ce++;
        end
        chk("idle_flush_blocks_grant", 512'(ce), 512'(0));
        if_flush = 1'b0;
        wait_grant(1'b0, 10, "idle_flush_release", got);
        repeat (10) @(negedge clock);

        // Reset during WAIT discards the transaction; wait for ddr_ready.
        resp_lat = 80;
        @(negedge clock);
        if_req_valid = 1'b1; if_req_index = 19'h1234B;
        wait_grant(1'b0, 20, "rst_wait", got);
        repeat (10) @(negedge clock);
        ddr_ready = 1'b0;
        do_reset();
        resp_lat = 3;
        lsu_req_valid = 1'b1; lsu_req_index = 19'h00044; lsu_req_write = 1'b0;
        ce = 0;
        repeat (10) begin
            @(negedge clock);
            if (ddr_chip_enable === 1'b1 || lsu_req_ready === 1'b1) ce++;
        end
        chk("no_issue_without_ddr_ready", 512'(ce), 512'(0));
        ddr_ready = 1'b1;
        wait_grant(1'b1, 6, "post_reset", got);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (lsu_resp_valid === 1'b1) begin got = 1'b1; break; end
        end
        chk("post_reset_resp", 512'(got), 512'(1));
        chk("post_reset_rdata", 512'(lsu_resp_rdata), 512'(mem_word(19'h00044)));

`ifdef DDR_ARB_WATCHDOG_EN
        // Responder never completes: watchdog forces a zero-data response.
        chk("wd_err_clear_before", 512'(timeout_err), 512'(0));
        resp_hang = 1'b1;
        @(negedge clock);
        lsu_req_valid = 1'b1; lsu_req_index = 19'h00055; lsu_req_write = 1'b0;
        wait_grant(1'b1, 20, "wd", got);
        got = 1'b0; n = 0;
        for (int c = 0; c < 260; c++) begin
            @(negedge clock);
            n++;
            if (lsu_resp_valid === 1'b1) begin got = 1'b1; break; end
        end
        chk("wd_resp_seen", 512'(got), 512'(1));
        chk("wd_resp_after_200_wait", 512'(n), 512'(201));
        chk("wd_rdata_zero", 512'(lsu_resp_rdata), 512'(0));
        chk("wd_timeout_err", 512'(timeout_err), 512'(1));
        resp_hang = 1'b0;
        repeat (5) @(negedge clock);
        chk("wd_timeout_err_sticky", 512'(timeout_err), 512'(1));
`else
        chk("timeout_err_tied_low", 512'(timeout_err), 512'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
